// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM capture path
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_DIV
    } pwm_state_e;

    localparam int DUTY_W     = 3;
    localparam int DIV_STEPS  = 3;
    // Filter depth tracks the generator's speed-code width so both ends agree on minimum pulse width.
    localparam int FILT_DEPTH = DUTY_W;

    function automatic logic [DUTY_W-1:0] duty_from_level(input logic lvl);
        return lvl ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - pad synchroniser with rise detect; glitch filter when PWM_DECODER_GLITCH_FILTER_EN is defined
module pwm_sync_edge
    import pwm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic level_d;
    logic level_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            meta_q       <= din_i;
            sync_q       <= meta_q;
            level_prev_q <= level_d;
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic [FILT_DEPTH-2:0] hist_q;
    logic                  filt_q;

    // Level flips only once the current sample and the previous FILT_DEPTH-1 samples agree.
    always_comb begin
        level_d = filt_q;
        if (&{hist_q, sync_q}) begin
            level_d = 1'b1;
        end else if (~|{hist_q, sync_q}) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[FILT_DEPTH-3:0], sync_q};
            filt_q <= level_d;
        end
    end
`else
    assign level_d = sync_q;
`endif

    assign level_o = level_d;
    assign rise_o  = level_d & ~level_prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM period/high-time capture with 3-bit duty quantiser; filter option PWM_DECODER_GLITCH_FILTER_EN
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty_code,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam int              STEP_W  = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic s;
    logic rise;

    pwm_sync_edge u_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .din_i   (pwm_in),
        .level_o (s),
        .rise_o  (rise)
    );

    pwm_state_e          state_q, state_d;
    logic [CNT_W-1:0]    per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]    hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]    p_snap_q, p_snap_d;
    logic [CNT_W-1:0]    h_snap_q, h_snap_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DUTY_W-2:0]   quo_q, quo_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    high_q, high_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                valid_q, valid_d;
    logic                stuck_q, stuck_d;
    logic                overrun_q, overrun_d;

    // Remainder never exceeds the period, so the doubled value needs one extra bit only transiently.
    logic [CNT_W:0] rem_shift;
    logic           rem_ge;

    assign rem_shift = {rem_q, 1'b0};
    assign rem_ge    = rem_shift >= {1'b0, p_snap_q};

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q + 1'b1;
        hi_cnt_d  = hi_cnt_q + CNT_W'(s);
        p_snap_d  = p_snap_q;
        h_snap_d  = h_snap_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        step_d    = step_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                if (rise) begin
                    state_d   = ST_MEAS;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    p_snap_d  = per_cnt_q;
                    h_snap_d  = hi_cnt_q;
                    rem_d     = hi_cnt_q;
                    quo_d     = '0;
                    step_d    = '0;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                    state_d   = ST_DIV;
                end else if (per_cnt_q == CNT_MAX) begin
                    stuck_d   = 1'b1;
                    duty_d    = duty_from_level(s);
                    valid_d   = 1'b1;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (rise) begin
                    overrun_d = 1'b1;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                    state_d   = ST_MEAS;
                end else begin
                    rem_d  = rem_ge ? CNT_W'(rem_shift - {1'b0, p_snap_q}) : CNT_W'(rem_shift);
                    quo_d  = {quo_q[DUTY_W-3:0], rem_ge};
                    step_d = step_q + 1'b1;
                    if (step_q == STEP_W'(DIV_STEPS - 1)) begin
                        period_d = p_snap_q;
                        high_d   = h_snap_q;
                        duty_d   = {quo_q, rem_ge};
                        valid_d  = 1'b1;
                        stuck_d  = 1'b0;
                        state_d  = ST_MEAS;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_d   = ST_IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            valid_d   = 1'b0;
            period_d  = period_q;
            high_d    = high_q;
            duty_d    = duty_q;
            stuck_d   = stuck_q;
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            p_snap_q  <= '0;
            h_snap_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            step_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            p_snap_q  <= p_snap_d;
            h_snap_q  <= h_snap_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            step_q    <= step_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            overrun_q <= overrun_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign duty_code = duty_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign overrun   = overrun_q;

endmodule
